// File: rtl/div_seq_ctrl_pkg.sv
// div_seq_ctrl_pkg: shared constants, state encoding and operation context
// for the sequential divider controller.
// Optional feature macro used by div_seq_ctrl: DIV_ZERO_BYPASS_EN.
package div_seq_ctrl_pkg;

    // Default operand / quotient / remainder width.
    localparam int unsigned DIV_DW_DEFAULT = 32;

    // Controller states (3-bit binary encoding, kept as plain constants so the
    // encoding stays compatible with older consumers of these values).
    localparam logic [2:0] DIV_ST_IDLE  = 3'd0;
    localparam logic [2:0] DIV_ST_SEND  = 3'd1;
    localparam logic [2:0] DIV_ST_WAIT  = 3'd2;
    localparam logic [2:0] DIV_ST_DONE  = 3'd3;
    localparam logic [2:0] DIV_ST_DRAIN = 3'd4;

    // Context latched when a request is accepted.
    typedef struct packed {
        logic neg_q;   // quotient must be negated on capture
        logic neg_r;   // remainder must be negated on capture
        logic cancel;  // flushed while the operands were still being handed over
    } div_ctx_t;

    // Field split of the IP dout bus: quotient in the upper half,
    // remainder in the lower half.
    function automatic int unsigned div_quot_msb(input int unsigned dw);
        return 2 * dw - 1;
    endfunction

    function automatic int unsigned div_quot_lsb(input int unsigned dw);
        return dw;
    endfunction

    function automatic int unsigned div_rem_msb(input int unsigned dw);
        return dw - 1;
    endfunction

endpackage

// File: rtl/div_sign_fix.sv
// div_sign_fix: conditional two's-complement negation. Produces the magnitude
// of a signed operand at acceptance, and re-applies the sign to the IP's
// quotient/remainder at capture.
module div_sign_fix
    import div_seq_ctrl_pkg::*;
#(
    parameter int unsigned DW = DIV_DW_DEFAULT
) (
    input  logic [DW-1:0] in_val,
    input  logic          neg,
    output logic [DW-1:0] out_val
);

    // Negate when requested, otherwise pass the value through unchanged.
    always_comb begin
        out_val = in_val;
        if (neg) begin
            out_val = '0 - in_val;
        end
    end

endmodule

// File: rtl/div_seq_ctrl.sv
// div_seq_ctrl: sequences one shared unsigned AXI-stream divider IP for
// DIV/DIVU on behalf of the execute stage. Signed operands are reduced to
// magnitudes before issue and the sign is restored on the captured result.
// A flush drains any in-flight IP operation so the IP never returns a stale
// result to a later request.
// Optional feature: define DIV_ZERO_BYPASS_EN to answer a zero divisor
// directly (quot = all ones, rem = dividend) without using the IP.
module div_seq_ctrl
    import div_seq_ctrl_pkg::*;
#(
    parameter int unsigned DW = DIV_DW_DEFAULT
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_signed,
    input  logic [DW-1:0]   req_dividend,
    input  logic [DW-1:0]   req_divisor,
    input  logic            flush,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [DW-1:0]   resp_quot,
    output logic [DW-1:0]   resp_rem,
    output logic            busy,
    output logic            m_dividend_tvalid,
    input  logic            m_dividend_tready,
    output logic [DW-1:0]   m_dividend_tdata,
    output logic            m_divisor_tvalid,
    input  logic            m_divisor_tready,
    output logic [DW-1:0]   m_divisor_tdata,
    input  logic            s_dout_tvalid,
    input  logic [2*DW-1:0] s_dout_tdata
);

    localparam int unsigned QUOT_MSB = div_quot_msb(DW);
    localparam int unsigned QUOT_LSB = div_quot_lsb(DW);
    localparam int unsigned REM_MSB  = div_rem_msb(DW);

    logic [2:0]    state;
    logic [2:0]    state_nxt;
    div_ctx_t      ctx;

    logic          accept;
    logic          zero_bypass;
    logic          dvd_neg;
    logic          dvs_neg;
    logic          dvd_done;
    logic          dvs_done;
    logic          send_done;
    logic          capture;

    logic [DW-1:0] dvd_mag;
    logic [DW-1:0] dvs_mag;
    logic [DW-1:0] ip_quot;
    logic [DW-1:0] ip_rem;
    logic [DW-1:0] fix_quot;
    logic [DW-1:0] fix_rem;

    // ------------------------------------------------------------------
    // Request side
    // ------------------------------------------------------------------
    assign req_ready  = (state == DIV_ST_IDLE) && !flush;
    assign accept     = req_valid && req_ready;
    assign busy       = (state != DIV_ST_IDLE);
    assign resp_valid = (state == DIV_ST_DONE);

    assign dvd_neg = req_signed & req_dividend[DW-1];
    assign dvs_neg = req_signed & req_divisor[DW-1];

`ifdef DIV_ZERO_BYPASS_EN
    assign zero_bypass = (req_divisor == '0);
`else
    assign zero_bypass = 1'b0;
`endif

    div_sign_fix #(.DW(DW)) u_mag_dividend (
        .in_val  (req_dividend),
        .neg     (dvd_neg),
        .out_val (dvd_mag)
    );

    div_sign_fix #(.DW(DW)) u_mag_divisor (
        .in_val  (req_divisor),
        .neg     (dvs_neg),
        .out_val (dvs_mag)
    );

    // ------------------------------------------------------------------
    // IP side
    // ------------------------------------------------------------------
    // A channel is finished once its tvalid is low or is being accepted now.
    assign dvd_done  = !m_dividend_tvalid || m_dividend_tready;
    assign dvs_done  = !m_divisor_tvalid || m_divisor_tready;
    assign send_done = dvd_done && dvs_done;

    assign ip_quot = s_dout_tdata[QUOT_MSB:QUOT_LSB];
    assign ip_rem  = s_dout_tdata[REM_MSB:0];
    assign capture = (state == DIV_ST_WAIT) && s_dout_tvalid && !flush;

    div_sign_fix #(.DW(DW)) u_fix_quot (
        .in_val  (ip_quot),
        .neg     (ctx.neg_q),
        .out_val (fix_quot)
    );

    div_sign_fix #(.DW(DW)) u_fix_rem (
        .in_val  (ip_rem),
        .neg     (ctx.neg_r),
        .out_val (fix_rem)
    );

    // ------------------------------------------------------------------
    // Control
    // ------------------------------------------------------------------
    // Next-state selection. A flush never retracts an issued tvalid; the
    // operation is instead steered into DRAIN so its result is swallowed.
    always_comb begin
        state_nxt = state;
        case (state)
            DIV_ST_IDLE: begin
                if (accept) begin
                    state_nxt = zero_bypass ? DIV_ST_DONE : DIV_ST_SEND;
                end
            end
            DIV_ST_SEND: begin
                if (send_done) begin
                    state_nxt = (ctx.cancel || flush) ? DIV_ST_DRAIN : DIV_ST_WAIT;
                end
            end
            DIV_ST_WAIT: begin
                if (flush) begin
                    // A result arriving with the flush is already the one to discard.
                    state_nxt = s_dout_tvalid ? DIV_ST_IDLE : DIV_ST_DRAIN;
                end else if (s_dout_tvalid) begin
                    state_nxt = DIV_ST_DONE;
                end
            end
            DIV_ST_DONE: begin
                if (flush || resp_ready) begin
                    state_nxt = DIV_ST_IDLE;
                end
            end
            DIV_ST_DRAIN: begin
                if (s_dout_tvalid) begin
                    state_nxt = DIV_ST_IDLE;
                end
            end
            default: begin
                state_nxt = DIV_ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= DIV_ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Operand channels: raise both tvalids on issue, drop each on its own handshake.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_dividend_tvalid <= 1'b0;
            m_divisor_tvalid  <= 1'b0;
            m_dividend_tdata  <= '0;
            m_divisor_tdata   <= '0;
        end else if (accept && !zero_bypass) begin
            m_dividend_tvalid <= 1'b1;
            m_divisor_tvalid  <= 1'b1;
            m_dividend_tdata  <= dvd_mag;
            m_divisor_tdata   <= dvs_mag;
        end else begin
            if (m_dividend_tvalid && m_dividend_tready) begin
                m_dividend_tvalid <= 1'b0;
            end
            if (m_divisor_tvalid && m_divisor_tready) begin
                m_divisor_tvalid <= 1'b0;
            end
        end
    end

    // Per-operation context: sign corrections and the cancelled-in-SEND mark.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ctx <= '0;
        end else if (accept) begin
            ctx.neg_q  <= req_signed & (req_dividend[DW-1] ^ req_divisor[DW-1]);
            ctx.neg_r  <= dvd_neg;
            ctx.cancel <= 1'b0;
        end else if ((state == DIV_ST_SEND) && flush) begin
            ctx.cancel <= 1'b1;
        end
    end

    // Result registers, held until the next capture.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            resp_quot <= '0;
            resp_rem  <= '0;
        end else if (accept && zero_bypass) begin
            resp_quot <= '1;
            resp_rem  <= req_dividend;
        end else if (capture) begin
            resp_quot <= fix_quot;
            resp_rem  <= fix_rem;
        end
    end

endmodule

// File: tb/tb_div_seq_ctrl.sv
// tb_div_seq_ctrl: self-checking bench for div_seq_ctrl with a behavioural
// model of the AXI-stream divider IP and a plain-arithmetic reference for
// DIV/DIVU results and response latency.
`timescale 1ns/1ps
module tb_div_seq_ctrl;

    localparam int unsigned DW = 32;

    logic            clk = 1'b0;
    logic            resetn;
    logic            req_valid;
    logic            req_ready;
    logic            req_signed;
    logic [DW-1:0]   req_dividend;
    logic [DW-1:0]   req_divisor;
    logic            flush;
    logic            resp_valid;
    logic            resp_ready;
    logic [DW-1:0]   resp_quot;
    logic [DW-1:0]   resp_rem;
    logic            busy;
    logic            m_dividend_tvalid;
    logic            m_dividend_tready;
    logic [DW-1:0]   m_dividend_tdata;
    logic            m_divisor_tvalid;
    logic            m_divisor_tready;
    logic [DW-1:0]   m_divisor_tdata;
    logic            s_dout_tvalid;
    logic [2*DW-1:0] s_dout_tdata;

    always #5 clk = ~clk;

    div_seq_ctrl #(.DW(DW)) dut (
        .clk               (clk),
        .resetn            (resetn),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_signed        (req_signed),
        .req_dividend      (req_dividend),
        .req_divisor       (req_divisor),
        .flush             (flush),
        .resp_valid        (resp_valid),
        .resp_ready        (resp_ready),
        .resp_quot         (resp_quot),
        .resp_rem          (resp_rem),
        .busy              (busy),
        .m_dividend_tvalid (m_dividend_tvalid),
        .m_dividend_tready (m_dividend_tready),
        .m_dividend_tdata  (m_dividend_tdata),
        .m_divisor_tvalid  (m_divisor_tvalid),
        .m_divisor_tready  (m_divisor_tready),
        .m_divisor_tdata   (m_divisor_tdata),
        .s_dout_tvalid     (s_dout_tvalid),
        .s_dout_tdata      (s_dout_tdata)
    );

    int unsigned checks = 0;
    int unsigned errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: truncating division with remainder taking the dividend's sign.
    // Zero divisor is only exercised unsigned: all-ones quotient, dividend remainder.
    function automatic void ref_div(input logic sgn, input logic [DW-1:0] a, input logic [DW-1:0] b,
                                    output logic [DW-1:0] q, output logic [DW-1:0] r);
        longint sa, sb, lq, lr;
        if (b == '0) begin
            q = '1;
            r = a;
        end else if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            lq = sa / sb;
            lr = sa % sb;
            q  = lq[DW-1:0];
            r  = lr[DW-1:0];
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    // ---------------- divider IP model ----------------
    int          dvd_delay = 0;
    int          dvs_delay = 0;
    int          ip_lat = 1;
    int          dvd_wait = 0;
    int          dvs_wait = 0;
    int          dvd_hi = 0;
    int          dvs_hi = 0;
    int          cd = 0;
    logic        got_a = 1'b0;
    logic        got_b = 1'b0;
    logic [DW-1:0] ip_a, ip_b, ip_q, ip_r, dvd_prev, dvs_prev;

    // Everything changes on the falling edge; a channel's tready rises once its
    // tvalid has been up for delay+1 cycles, and the result pulse appears
    // ip_lat full cycles after the cycle in which the last operand was taken.
    always @(negedge clk) begin
        if (!resetn) begin
            cd = 0; got_a = 1'b0; got_b = 1'b0; dvd_wait = 0; dvs_wait = 0;
            m_dividend_tready = 1'b0; m_divisor_tready = 1'b0;
            s_dout_tvalid = 1'b0; s_dout_tdata = '0;
        end else begin
            s_dout_tvalid = 1'b0;
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    s_dout_tvalid = 1'b1;
                    s_dout_tdata  = {ip_q, ip_r};
                end
            end
            if (m_dividend_tvalid) begin
                if (dvd_wait > 0) check_eq("dividend_tdata_stable", m_dividend_tdata, dvd_prev);
                dvd_prev = m_dividend_tdata;
                dvd_wait++; dvd_hi++;
                m_dividend_tready = (dvd_wait > dvd_delay);
                if (m_dividend_tready) begin ip_a = m_dividend_tdata; got_a = 1'b1; dvd_wait = 0; end
            end else begin
                m_dividend_tready = 1'b0; dvd_wait = 0;
            end
            if (m_divisor_tvalid) begin
                if (dvs_wait > 0) check_eq("divisor_tdata_stable", m_divisor_tdata, dvs_prev);
                dvs_prev = m_divisor_tdata;
                dvs_wait++; dvs_hi++;
                m_divisor_tready = (dvs_wait > dvs_delay);
                if (m_divisor_tready) begin ip_b = m_divisor_tdata; got_b = 1'b1; dvs_wait = 0; end
            end else begin
                m_divisor_tready = 1'b0; dvs_wait = 0;
            end
            if (got_a && got_b) begin
                got_a = 1'b0; got_b = 1'b0;
                ip_q = (ip_b == '0) ? '1 : ip_a / ip_b;
                ip_r = (ip_b == '0) ? ip_a : ip_a % ip_b;
                cd = ip_lat + 1;
            end
        end
    end

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (!req_ready && n < 60) begin
            @(negedge clk); #1; n++;
        end
        check_eq(tag, req_ready, 1'b1);
    endtask

    // One full operation: present, accept, wait for the response, hold it
    // for rdly cycles, then consume it.
    task automatic do_op(input logic sgn, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input int dd, input int ds, input int lat, input int rdly);
        logic [DW-1:0] eq, er, hq, hr;
        int exp_lat, cnt;
        logic bypass;
        ref_div(sgn, a, b, eq, er);
        bypass = 1'b0;
`ifdef DIV_ZERO_BYPASS_EN
        bypass = (b == '0);
`endif
        exp_lat = bypass ? 1 : 3 + ((dd > ds) ? dd : ds) + lat;
        dvd_delay = dd; dvs_delay = ds; ip_lat = lat;
        req_valid = 1'b1; req_signed = sgn; req_dividend = a; req_divisor = b;
        #1;
        wait_ready("req_ready");
        dvd_hi = 0; dvs_hi = 0;
        @(negedge clk);
        req_valid = 1'b0;
        cnt = 1;
        check_eq("busy_after_accept", busy, 1'b1);
        while (!resp_valid && cnt < 200) begin
            @(negedge clk); cnt++;
        end
        check_eq("latency", cnt, exp_lat);
        check_eq("quot", resp_quot, eq);
        check_eq("rem", resp_rem, er);
        check_eq("dividend_tvalid_cycles", dvd_hi, bypass ? 0 : dd + 1);
        check_eq("divisor_tvalid_cycles", dvs_hi, bypass ? 0 : ds + 1);
        hq = resp_quot; hr = resp_rem;
        repeat (rdly) begin
            @(negedge clk);
            check_eq("resp_valid_held", resp_valid, 1'b1);
            check_eq("resp_held", {resp_quot, resp_rem}, {hq, hr});
        end
        check_eq("req_ready_in_done", req_ready, 1'b0);
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        check_eq("resp_valid_after_take", resp_valid, 1'b0);
        check_eq("busy_after_take", busy, 1'b0);
    endtask

    // Flush for one cycle at cycle fcyc after acceptance, then present DIVU 9/3.
    // The IP still delivers its pulse; new acceptance is possible only once the
    // controller is back in IDLE.
    task automatic flush_case(input int fcyc, input int ds, input int lat);
        int h, p, exp_rdy, c;
        h = ds + 1;
        p = h + lat + 1;
        exp_rdy = (p > fcyc) ? p + 1 : fcyc + 1;
        dvd_delay = 0; dvs_delay = ds; ip_lat = lat;
        req_valid = 1'b1; req_signed = 1'b0; req_dividend = 32'd1000; req_divisor = 32'd3;
        #1;
        wait_ready("flush_accept_ready");
        c = 0;
        while (c < exp_rdy) begin
            @(negedge clk); c++;
            flush = (c == fcyc);
            if (c > fcyc) begin
                req_valid = 1'b1; req_dividend = 32'd9; req_divisor = 32'd3;
            end else begin
                req_valid = 1'b0;
            end
            #1;
            check_eq("flush_resp_valid", resp_valid, (c > p) && (c <= fcyc));
            if (c > fcyc) check_eq("flush_req_ready", req_ready, c >= exp_rdy);
        end
        flush = 1'b0;
        do_op(1'b0, 32'd9, 32'd3, 0, 0, 3, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        resetn = 1'b0; req_valid = 1'b0; req_signed = 1'b0; req_dividend = '0;
        req_divisor = '0; flush = 1'b0; resp_ready = 1'b0;
        #1;
        check_eq("rst_resp_valid", resp_valid, 1'b0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_dividend_tvalid", m_dividend_tvalid, 1'b0);
        check_eq("rst_divisor_tvalid", m_divisor_tvalid, 1'b0);
        check_eq("rst_quot", resp_quot, '0);
        check_eq("rst_rem", resp_rem, '0);
        @(negedge clk); #3 resetn = 1'b1;
        @(negedge clk);

        // Flush in IDLE blocks acceptance.
        flush = 1'b1; req_valid = 1'b1; req_dividend = 32'd5; req_divisor = 32'd1;
        #1 check_eq("idle_flush_ready", req_ready, 1'b0);
        @(negedge clk); flush = 1'b0; req_valid = 1'b0;
        check_eq("idle_flush_busy", busy, 1'b0);

        // Directed cases.
        do_op(1'b0, 32'd100, 32'd7, 0, 0, 10, 3);
        do_op(1'b1, -32'sd7, 32'd2, 0, 0, 4, 0);
        do_op(1'b1, 32'd7, -32'sd2, 1, 0, 2, 1);
        do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1, 5, 0);
        do_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 1, 0);
        do_op(1'b0, 32'd1234, 32'd1234, 0, 3, 6, 2);
        do_op(1'b0, 32'd5, 32'd0, 0, 0, 3, 1);

        // Flush in SEND, in WAIT, coincident with the result pulse, and in DONE.
        flush_case(1, 2, 6);
        flush_case(5, 2, 6);
        flush_case(10, 2, 6);
        flush_case(12, 2, 6);

        // Asynchronous reset in the middle of WAIT.
        dvd_delay = 0; dvs_delay = 0; ip_lat = 10;
        req_valid = 1'b1; req_signed = 1'b0; req_dividend = 32'd1000; req_divisor = 32'd7;
        #1;
        wait_ready("reset_case_ready");
        @(negedge clk); req_valid = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("busy_before_reset", busy, 1'b1);
        #2 resetn = 1'b0;
        #1;
        check_eq("async_rst_busy", busy, 1'b0);
        check_eq("async_rst_resp_valid", resp_valid, 1'b0);
        check_eq("async_rst_tvalids", {m_dividend_tvalid, m_divisor_tvalid}, 2'b00);
        check_eq("async_rst_quot", resp_quot, '0);
        check_eq("async_rst_rem", resp_rem, '0);
        @(negedge clk); #3 resetn = 1'b1;
        @(negedge clk);
        do_op(1'b0, 32'd77, 32'd5, 1, 0, 4, 1);

        // Randomized operations.
        for (int i = 0; i < 40; i++) begin
            logic sgn;
            logic [DW-1:0] a, b;
            sgn = 1'(($urandom % 2));
            a = $urandom;
            if ($urandom % 8 == 0) a = 32'h8000_0000;
            b = $urandom;
            if ($urandom % 3 == 0) b = $urandom_range(1, 15);
            if (sgn && ($urandom % 3 == 0)) b = '0 - 32'($urandom_range(1, 15));
            if (b == '0) b = 32'd1;
            do_op(sgn, a, b, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  int'($urandom_range(1, 12)), int'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
